// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap/redirect sequencer and the fetch unit:
// state encoding, datapath width and the default boot vector.
package trap_ctrl_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] TRAP_RST      = 3'd0;
  localparam logic [STATE_W-1:0] TRAP_BOOT     = 3'd1;
  localparam logic [STATE_W-1:0] TRAP_RUN      = 3'd2;
  localparam logic [STATE_W-1:0] TRAP_INT_REQ  = 3'd3;
  localparam logic [STATE_W-1:0] TRAP_DRAIN    = 3'd4;
  localparam logic [STATE_W-1:0] TRAP_REDIRECT = 3'd5;
  localparam logic [STATE_W-1:0] TRAP_SETTLE   = 3'd6;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h8000_0000;

  typedef enum logic [STATE_W-1:0] {
    ST_RST      = TRAP_RST,
    ST_BOOT     = TRAP_BOOT,
    ST_RUN      = TRAP_RUN,
    ST_INT_REQ  = TRAP_INT_REQ,
    ST_DRAIN    = TRAP_DRAIN,
    ST_REDIRECT = TRAP_REDIRECT,
    ST_SETTLE   = TRAP_SETTLE
  } trap_state_e;

endpackage

// File: rtl/trap_ctrl_if.sv
// Core-side bundle of the trap sequencer: WB/CSR/bus status in, pipeline
// control and fetch redirect handshake out.
interface trap_ctrl_if;
  import trap_ctrl_pkg::*;

  logic            wb_valid_i;
  logic            exc_taken_i;
  logic [XLEN-1:0] exc_ret_addr_i;
  logic            int_pending_i;
  logic            mem_busy_i;
  logic            redir_ready_i;
  logic            int_take_o;
  logic            stall_o;
  logic            flush_o;
  logic            redir_valid_o;
  logic [XLEN-1:0] redir_addr_o;
  logic [XLEN-1:0] trap_count_o;
  logic            busy_o;

  // Core / fetch side
  modport master (
    output wb_valid_i, exc_taken_i, exc_ret_addr_i, int_pending_i,
           mem_busy_i, redir_ready_i,
    input  int_take_o, stall_o, flush_o, redir_valid_o, redir_addr_o,
           trap_count_o, busy_o
  );

  // Sequencer side
  modport slave (
    input  wb_valid_i, exc_taken_i, exc_ret_addr_i, int_pending_i,
           mem_busy_i, redir_ready_i,
    output int_take_o, stall_o, flush_o, redir_valid_o, redir_addr_o,
           trap_count_o, busy_o
  );
endinterface

// File: rtl/trap_ctrl.sv
// Trap / xRET / interrupt sequencer: freezes and flushes IF..MEM, waits for
// the data bus to drain, then hands the new fetch address to the fetch unit.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC      = DEFAULT_RESET_PC,
  parameter int unsigned     SETTLE_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  trap_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] SETTLE_LOAD =
    (SETTLE_CYCLES == 0) ? CNT_W'(0) : CNT_W'(SETTLE_CYCLES - 1);

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] count_q, count_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic            trigger_c;

  assign trigger_c = bus.wb_valid_i & bus.exc_taken_i;

  // State, redirect address, trap counter and settle counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_RST;
      addr_q   <= '0;
      count_q  <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      settle_q <= settle_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    settle_d = settle_q;
    case (state_q)
      ST_RST: begin
        state_d = ST_BOOT;
        addr_d  = RESET_PC;
      end
      ST_BOOT: begin
        if (bus.redir_ready_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (trigger_c) begin
          addr_d  = bus.exc_ret_addr_i;
          state_d = ST_DRAIN;
        end else if (bus.wb_valid_i && bus.int_pending_i) begin
          state_d = ST_INT_REQ;
        end
      end
      ST_INT_REQ: begin
        if (trigger_c) begin
          addr_d  = bus.exc_ret_addr_i;
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!bus.mem_busy_i) state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (bus.redir_ready_i) begin
          count_d = count_q + XLEN'(1);
          if (SETTLE_CYCLES == 0) begin
            state_d = ST_RUN;
          end else begin
            state_d  = ST_SETTLE;
            settle_d = SETTLE_LOAD;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) state_d = ST_RUN;
        else                settle_d = settle_q - CNT_W'(1);
      end
      default: state_d = ST_RST;
    endcase
  end

  // Moore decode; only the RUN trigger term reaches stall/flush combinationally.
  // RST itself keeps the pipeline controls low so every output but busy is 0.
  logic hold_c;
  assign hold_c = ((state_q == ST_RUN) && trigger_c) ||
                  ((state_q != ST_RUN) && (state_q != ST_RST));

  assign bus.int_take_o    = (state_q == ST_INT_REQ);
  assign bus.stall_o       = hold_c;
  assign bus.flush_o       = hold_c;
  assign bus.redir_valid_o = (state_q == ST_BOOT) || (state_q == ST_REDIRECT);
  assign bus.redir_addr_o  = addr_q;
  assign bus.trap_count_o  = count_q;
  assign bus.busy_o        = (state_q != ST_RUN);

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: a cycle-by-cycle vector table plus sequences
// for reset during a redirect and trap-counter wrap.
module tb_trap_ctrl;

  localparam logic [31:0] BOOT = 32'h8000_0000;

  typedef struct {
    logic        wv, ex;
    logic [31:0] ea;
    logic        ip, mb, rdy;
    logic        it, sf, rv;
    logic [31:0] addr, cnt;
    logic        busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  trap_ctrl_if tif();

  trap_ctrl #(.RESET_PC(BOOT), .SETTLE_CYCLES(2)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (tif)
  );

  function automatic vec_t mk(logic wv, logic ex, logic [31:0] ea, logic ip,
                              logic mb, logic rdy, logic it, logic sf, logic rv,
                              logic [31:0] addr, logic [31:0] cnt, logic busy);
    vec_t v;
    v.wv = wv; v.ex = ex; v.ea = ea; v.ip = ip; v.mb = mb; v.rdy = rdy;
    v.it = it; v.sf = sf; v.rv = rv; v.addr = addr; v.cnt = cnt; v.busy = busy;
    return v;
  endfunction

  task automatic drive(logic wv, logic ex, logic [31:0] ea, logic ip,
                       logic mb, logic rdy);
    tif.wb_valid_i     = wv;
    tif.exc_taken_i    = ex;
    tif.exc_ret_addr_i = ea;
    tif.int_pending_i  = ip;
    tif.mem_busy_i     = mb;
    tif.redir_ready_i  = rdy;
  endtask

  task automatic check(string name, logic it, logic sf, logic rv,
                       logic [31:0] addr, logic [31:0] cnt, logic busy);
    n_vec++;
    if (tif.int_take_o !== it || tif.stall_o !== sf || tif.flush_o !== sf ||
        tif.redir_valid_o !== rv || tif.redir_addr_o !== addr ||
        tif.trap_count_o !== cnt || tif.busy_o !== busy) begin
      n_err++;
      $display("FAIL %s: got it=%b st=%b fl=%b rv=%b addr=%h cnt=%h busy=%b, exp it=%b st/fl=%b rv=%b addr=%h cnt=%h busy=%b",
               name, tif.int_take_o, tif.stall_o, tif.flush_o, tif.redir_valid_o,
               tif.redir_addr_o, tif.trap_count_o, tif.busy_o,
               it, sf, rv, addr, cnt, busy);
    end
  endtask

  initial begin
    drive(0, 0, 32'h0, 0, 0, 0);

    //           wv ex ea            ip mb rdy  it sf rv addr          cnt busy
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 0,  0, 0, 0, 32'h0,     0, 1)); // RST
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 0,  0, 1, 1, BOOT,      0, 1)); // BOOT
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 0,  0, 1, 1, BOOT,      0, 1));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 0,  0, 1, 1, BOOT,      0, 1));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 1,  0, 1, 1, BOOT,      0, 1));
    vecs.push_back(mk(1, 0, 32'h0,     0, 0, 1,  0, 0, 0, BOOT,      0, 0)); // RUN
    vecs.push_back(mk(1, 1, 32'h100,   0, 0, 1,  0, 1, 0, BOOT,      0, 0)); // ECALL T
    vecs.push_back(mk(1, 1, 32'h999,   1, 0, 1,  0, 1, 0, 32'h100,   0, 1)); // DRAIN
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 1,  0, 1, 1, 32'h100,   0, 1)); // REDIRECT
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 1,  0, 1, 0, 32'h100,   1, 1)); // SETTLE
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 1,  0, 1, 0, 32'h100,   1, 1));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 1,  0, 0, 0, 32'h100,   1, 0)); // RUN T+5
    vecs.push_back(mk(1, 1, 32'h200,   0, 0, 1,  0, 1, 0, 32'h100,   1, 0)); // trap, busy bus
    vecs.push_back(mk(1, 1, 32'h300,   0, 1, 1,  0, 1, 0, 32'h200,   1, 1));
    vecs.push_back(mk(0, 0, 32'h300,   0, 1, 1,  0, 1, 0, 32'h200,   1, 1));
    vecs.push_back(mk(0, 0, 32'h300,   0, 1, 1,  0, 1, 0, 32'h200,   1, 1));
    vecs.push_back(mk(0, 0, 32'h300,   0, 1, 1,  0, 1, 0, 32'h200,   1, 1));
    vecs.push_back(mk(0, 0, 32'h300,   0, 0, 1,  0, 1, 0, 32'h200,   1, 1));
    vecs.push_back(mk(0, 0, 32'h400,   0, 0, 0,  0, 1, 1, 32'h200,   1, 1)); // T+6
    vecs.push_back(mk(0, 0, 32'h400,   0, 0, 1,  0, 1, 1, 32'h200,   1, 1));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 0,  0, 1, 0, 32'h200,   2, 1));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 0,  0, 1, 0, 32'h200,   2, 1));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 0,  0, 0, 0, 32'h200,   2, 0));
    vecs.push_back(mk(1, 0, 32'h0,     1, 0, 0,  0, 0, 0, 32'h200,   2, 0)); // int pending
    vecs.push_back(mk(1, 1, 32'h500,   1, 0, 0,  1, 1, 0, 32'h200,   2, 1)); // INT_REQ
    vecs.push_back(mk(0, 0, 32'h0,     1, 0, 0,  0, 1, 0, 32'h500,   2, 1)); // DRAIN
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 1,  0, 1, 1, 32'h500,   2, 1));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 0,  0, 1, 0, 32'h500,   3, 1));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 0,  0, 1, 0, 32'h500,   3, 1));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 0,  0, 0, 0, 32'h500,   3, 0));
    vecs.push_back(mk(1, 0, 32'h0,     1, 0, 0,  0, 0, 0, 32'h500,   3, 0)); // int, withdrawn
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 0,  1, 1, 0, 32'h500,   3, 1));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 0,  0, 0, 0, 32'h500,   3, 0));
    vecs.push_back(mk(1, 1, 32'h600,   1, 0, 0,  0, 1, 0, 32'h500,   3, 0)); // exc + int
    vecs.push_back(mk(0, 0, 32'h0,     1, 0, 1,  0, 1, 0, 32'h600,   3, 1));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 1,  0, 1, 1, 32'h600,   3, 1));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 0,  0, 1, 0, 32'h600,   4, 1));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 0,  0, 1, 0, 32'h600,   4, 1));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 0,  0, 0, 0, 32'h600,   4, 0));
    vecs.push_back(mk(0, 1, 32'h777,   1, 0, 0,  0, 0, 0, 32'h600,   4, 0)); // no wb_valid
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 0,  0, 0, 0, 32'h600,   4, 0));

    repeat (2) @(negedge clk);
    #1 check("reset_hold", 0, 0, 0, 32'h0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].wv, vecs[i].ex, vecs[i].ea, vecs[i].ip, vecs[i].mb, vecs[i].rdy);
      #1 check($sformatf("vec%0d", i), vecs[i].it, vecs[i].sf, vecs[i].rv,
               vecs[i].addr, vecs[i].cnt, vecs[i].busy);
      @(negedge clk);
    end

    // Reset asserted while a redirect is pending
    drive(1, 1, 32'h700, 0, 0, 0);
    #1 check("rr_trap", 0, 1, 0, 32'h600, 4, 0);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 0, 0);
    #1 check("rr_drain", 0, 1, 0, 32'h700, 4, 1);
    @(negedge clk);
    #1 check("rr_redirect", 0, 1, 1, 32'h700, 4, 1);
    #2 rst_n = 1'b0;
    #1 check("rr_async_reset", 0, 0, 0, 32'h0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rr_rst_state", 0, 0, 0, 32'h0, 0, 1);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 0, 1);
    #1 check("rr_boot", 0, 1, 1, BOOT, 0, 1);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 0, 0);
    #1 check("rr_run", 0, 0, 0, BOOT, 0, 0);

    // Trap counter wrap from all-ones
    force dut.count_q = 32'hFFFF_FFFF;
    #1 check("wrap_preload", 0, 0, 0, BOOT, 32'hFFFF_FFFF, 0);
    @(posedge clk);
    #1 release dut.count_q;
    @(negedge clk);
    drive(1, 1, 32'h800, 0, 0, 1);
    #1 check("wrap_trap", 0, 1, 0, BOOT, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 0, 1);
    #1 check("wrap_drain", 0, 1, 0, 32'h800, 32'hFFFF_FFFF, 1);
    @(negedge clk);
    #1 check("wrap_redirect", 0, 1, 1, 32'h800, 32'hFFFF_FFFF, 1);
    @(negedge clk);
    #1 check("wrap_settle", 0, 1, 0, 32'h800, 32'h0, 1);
    repeat (2) @(negedge clk);
    #1 check("wrap_run", 0, 0, 0, 32'h800, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
